// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display fetch, host and block RAM signals around the VRAM arbiter
interface vram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              disp_ena;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_rdata;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
   logic              host_starved;
   logic              starve_clr;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ena;
   logic              ram_wena;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  disp_ena, disp_addr, host_req, host_we, host_addr, host_wdata, starve_clr, ram_rdata,
      output disp_rdata, host_ack, host_rdata, host_rvalid, host_starved,
             ram_addr, ram_ena, ram_wena, ram_wdata
   );

   modport master (
      output disp_ena, disp_addr, host_req, host_we, host_addr, host_wdata, starve_clr, ram_rdata,
      input  disp_rdata, host_ack, host_rdata, host_rvalid, host_starved,
             ram_addr, ram_ena, ram_wena, ram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the character/colour RAM port; display has absolute priority, host uses blanking cycles
module vram_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 1024
) (
   input logic           CLK_108MHz,
   input logic           reset,
   vram_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic {IDLE, RDWAIT} state_t;

   state_t        state, state_nxt;
   logic          grant;
   logic [CW-1:0] wait_ctr, wait_nxt;

   assign bus.disp_rdata = bus.ram_rdata;

   // host grant, RAM pin steering, next state and denied-request counter
   always_comb begin
      grant = bus.host_req & ~bus.disp_ena & (state == IDLE) & ~reset;
      state_nxt = state;
      if (state == RDWAIT) state_nxt = IDLE;
      else if (grant & ~bus.host_we) state_nxt = RDWAIT;
      wait_nxt = (bus.host_req & ~grant) ? ((wait_ctr == LIMIT) ? wait_ctr : wait_ctr + CW'(1)) : '0;
      bus.host_ack = grant;
      bus.ram_ena = ~reset & (bus.disp_ena | grant);
      bus.ram_addr = (~reset & bus.disp_ena) ? bus.disp_addr : grant ? bus.host_addr : '0;
      bus.ram_wena = grant & bus.host_we;
      bus.ram_wdata = (grant & bus.host_we) ? bus.host_wdata : '0;
   end

   // state, wait counter, sticky starvation flag and host read return
   always_ff @(posedge CLK_108MHz) begin
      if (reset) begin
         state <= IDLE;
         wait_ctr <= '0;
         bus.host_rdata <= '0;
         bus.host_rvalid <= 1'b0;
         bus.host_starved <= 1'b0;
      end else begin
         state <= state_nxt;
         wait_ctr <= wait_nxt;
         bus.host_rvalid <= (state == RDWAIT);
         if (state == RDWAIT) bus.host_rdata <= bus.ram_rdata;
         bus.host_starved <= (wait_nxt == LIMIT) | (bus.host_starved & ~bus.starve_clr);
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed stimulus against a cycle-level reference of the arbitration rules
module tb_vram_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int SL = 4;

   logic CLK_108MHz = 1'b0;
   logic reset = 1'b1;

   always #5 CLK_108MHz = ~CLK_108MHz;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .CLK_108MHz(CLK_108MHz),
      .reset(reset),
      .bus(bus)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return 16'h1F41 ^ 16'((a ^ 16'h0123) * 16'd40503);
   endfunction

   // block RAM with one-cycle read latency, read-before-write
   logic [DW-1:0] ram [0:65535];
   bit            ram_wr [0:65535];

   always @(posedge CLK_108MHz) begin
      if (bus.ram_ena) begin
         bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_val(bus.ram_addr);
         if (bus.ram_wena) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            ram_wr[bus.ram_addr] <= 1'b1;
         end
      end
   end

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // reference model state
   logic [DW-1:0] ref_mem [int];
   int            cyc = 0;
   int            last_rd = -100;
   logic [DW-1:0] rd_val = '0;
   logic          exp_rvalid = 1'b0;
   logic [DW-1:0] exp_rdata = '0;
   logic          exp_starved = 1'b0;
   int            run = 0;
   bit            prev_disp = 0;
   logic [DW-1:0] prev_disp_val = '0;
   bit            last_g = 0;

   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   task automatic cycle();
      bit            busy, g, en, we;
      logic [AW-1:0] ad;
      @(negedge CLK_108MHz);
      busy = (cyc == last_rd + 1);
      g = bus.host_req && !bus.disp_ena && !busy && !reset;
      en = !reset && (bus.disp_ena || g);
      ad = reset ? '0 : bus.disp_ena ? bus.disp_addr : g ? bus.host_addr : '0;
      we = g && bus.host_we;
      check("host_ack", 32'(bus.host_ack), 32'(g));
      check("ram_ena", 32'(bus.ram_ena), 32'(en));
      check("ram_addr", 32'(bus.ram_addr), 32'(ad));
      check("ram_wena", 32'(bus.ram_wena), 32'(we));
      check("ram_wdata", 32'(bus.ram_wdata), we ? 32'(bus.host_wdata) : 32'd0);
      check("host_rvalid", 32'(bus.host_rvalid), 32'(exp_rvalid));
      check("host_rdata", 32'(bus.host_rdata), 32'(exp_rdata));
      check("host_starved", 32'(bus.host_starved), 32'(exp_starved));
      if (prev_disp) check("disp_rdata", 32'(bus.disp_rdata), 32'(prev_disp_val));
      last_g = g;
      if (reset) begin
         exp_rvalid = 1'b0;
         exp_rdata = '0;
         exp_starved = 1'b0;
         run = 0;
         last_rd = -100;
         prev_disp = 0;
      end else begin
         exp_rvalid = busy;
         if (busy) exp_rdata = rd_val;
         prev_disp = bus.disp_ena;
         if (bus.disp_ena) prev_disp_val = memval(bus.disp_addr);
         if (g && !bus.host_we) begin
            last_rd = cyc;
            rd_val = memval(bus.host_addr);
         end
         if (we) ref_mem[int'(bus.host_addr)] = bus.host_wdata;
         run = (bus.host_req && !g) ? run + 1 : 0;
         exp_starved = (run >= SL) || (exp_starved && !bus.starve_clr);
      end
      cyc++;
      @(posedge CLK_108MHz);
      #1;
   endtask

   int disp_run = 0;

   initial begin
      bus.disp_ena = 0;
      bus.disp_addr = '0;
      bus.host_req = 0;
      bus.host_we = 0;
      bus.host_addr = '0;
      bus.host_wdata = '0;
      bus.starve_clr = 0;
      reset = 1;
      repeat (3) cycle();
      reset = 0;
      cycle();
      // display only
      bus.disp_ena = 1;
      bus.disp_addr = 16'h0123;
      cycle();
      check("disp_preload", 32'(bus.disp_rdata), 32'h1F41);
      bus.disp_ena = 0;
      cycle();
      // host write in blanking, then display read-back
      bus.host_req = 1;
      bus.host_we = 1;
      bus.host_addr = 16'h0010;
      bus.host_wdata = 16'h0741;
      cycle();
      bus.host_req = 0;
      bus.disp_ena = 1;
      bus.disp_addr = 16'h0010;
      cycle();
      check("disp_after_wr", 32'(bus.disp_rdata), 32'h0741);
      bus.disp_ena = 0;
      cycle();
      // host read, held through the wait cycle
      bus.host_req = 1;
      bus.host_we = 0;
      cycle();
      cycle();
      bus.host_req = 0;
      cycle();
      cycle();
      // contention for 6 cycles (also drives starvation), then blanking
      bus.host_req = 1;
      bus.host_we = 1;
      bus.host_addr = 16'h0020;
      bus.host_wdata = 16'hBEEF;
      bus.disp_ena = 1;
      for (int i = 0; i < 6; i++) begin
         bus.disp_addr = 16'(16'h0100 + i);
         cycle();
      end
      bus.disp_ena = 0;
      cycle();
      bus.host_req = 0;
      cycle();
      bus.starve_clr = 1;
      cycle();
      bus.starve_clr = 0;
      cycle();
      // reset during the read wait cycle, then an immediate grant
      bus.host_req = 1;
      bus.host_we = 0;
      bus.host_addr = 16'h0020;
      cycle();
      bus.host_req = 0;
      reset = 1;
      cycle();
      reset = 0;
      bus.host_req = 1;
      cycle();
      bus.host_req = 0;
      repeat (3) cycle();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (disp_run == 0) begin
            bus.disp_ena = ~bus.disp_ena;
            disp_run = $urandom_range(1, 12);
         end
         disp_run--;
         bus.disp_addr = 16'($urandom_range(0, 63));
         if (bus.host_req && !last_g) begin
            if ($urandom_range(0, 99) < 3) bus.host_req = 0;
         end else begin
            bus.host_req = ($urandom_range(0, 99) < 50);
            bus.host_we = 1'($urandom_range(0, 1));
            bus.host_addr = 16'($urandom_range(0, 63));
            bus.host_wdata = 16'($urandom);
         end
         bus.starve_clr = ($urandom_range(0, 99) < 5);
         reset = ($urandom_range(0, 999) < 5);
         cycle();
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
